// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a circular byte FIFO; queued bytes go out as
// back-to-back frames with no idle gap between them.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  rx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] level
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count, count_nx;
   logic [15:0]   baud;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          wr_en, bit_end, frame_end, pop, to_idle;

   assign wr_en     = rx_valid && rx_ready;
   assign bit_end   = (baud == BAUD_LAST);
   assign frame_end = (state == STOP) && bit_end;
   // The FSM loads a byte from IDLE, or straight from the end of a stop bit.
   assign pop       = (count != '0) && ((state == IDLE) || frame_end);
   assign to_idle   = !pop && ((state == IDLE) || frame_end);
   assign count_nx  = count + LW'(wr_en) - LW'(pop);
   assign level     = count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rx_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         count    <= count_nx;
         rx_ready <= (count_nx != FULL);
         busy     <= !to_idle || (count_nx != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         tx      <= 1'b1;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
      end else begin
         case (state)
            IDLE: begin
               baud <= '0;
               tx   <= 1'b1;
               if (pop) begin
                  shift   <= mem[rd_ptr];
                  bit_cnt <= '0;
                  tx      <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud  <= '0;
                  tx    <= shift[0];
                  state <= DATA;
               end else begin
                  baud <= baud + 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud <= baud + 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud <= '0;
                  if (pop) begin
                     shift   <= mem[rd_ptr];
                     bit_cnt <= '0;
                     tx      <= 1'b0;
                     state   <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud <= baud + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               baud  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed stimulus pushes expected bytes into a queue,
// a line monitor decodes frames from tx and pops/compares them.
module tb_uart_tx_fifo;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       rx_ready, tx, busy;
   logic [2:0] level;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         frames = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   logic [9:0] last_bits = '0;

   int burst_lvl[6] = '{1, 1, 2, 3, 4, 4};
   int burst_rdy[6] = '{1, 1, 1, 1, 0, 0};

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx       (tx),
      .busy     (busy),
      .level    (level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("idle within bound", busy, 0);
   endtask

   // Line monitor: samples each bit mid-cell, compares the byte at the end of the stop bit.
   initial begin : monitor
      int         phase;
      logic [9:0] bits;
      phase = -1;
      bits  = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            phase = -1;
         end else begin
            if (phase < 0 && tx === 1'b0) begin
               phase = 0;
               starts.push_back(cyc);
            end
            if (phase >= 0) begin
               if (phase % CPB == CPB / 2) bits[phase / CPB] = tx;
               if (phase == FRAME - 1) begin
                  phase = -1;
                  last_bits = bits;
                  frames++;
                  chk("framing start/stop", {bits[9], bits[0]}, 2'b10);
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected frame: got %0h expected none", bits[8:1]);
                  end else begin
                     chk("frame data", bits[8:1], exp_q.pop_front());
                  end
               end else begin
                  phase++;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int   n, idx, lowseen;
      logic rdy;

      // reset state
      repeat (4) @(negedge clk);
      chk("reset tx", tx, 1);
      chk("reset busy", busy, 0);
      chk("reset rx_ready", rx_ready, 1);
      chk("reset level", level, 0);
      rst = 1'b1;

      // single byte 0xA5
      @(negedge clk);
      rx_data = 8'hA5; rx_valid = 1'b1; exp_q.push_back(8'hA5);
      @(negedge clk);
      chk("write level", level, 1);
      chk("write busy", busy, 1);
      chk("write tx still idle", tx, 1);
      rx_valid = 1'b0;
      @(negedge clk);
      chk("start bit tx", tx, 0);
      chk("popped level", level, 0);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("busy fall delay", n, FRAME);
      chk("A5 line bits", last_bits, 10'b1101001010);
      chk("A5 frame count", frames, 1);

      // burst of 6, last one dropped
      starts.delete();
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         rx_data = 8'(i + 1); rx_valid = 1'b1;
         if (i < 5) exp_q.push_back(8'(i + 1));
         @(negedge clk);
         chk("burst level", level, burst_lvl[i]);
         chk("burst rx_ready", rx_ready, burst_rdy[i]);
      end
      rx_valid = 1'b0;
      wait_idle(400);
      chk("burst pending", exp_q.size(), 0);
      chk("burst frame count", starts.size(), 5);
      for (int i = 1; i < starts.size(); i++)
         chk("burst period", starts[i] - starts[i-1], FRAME);

      // write presented on the stop-end edge of a full FIFO
      @(negedge clk);
      rx_data = 8'h30; rx_valid = 1'b1; exp_q.push_back(8'h30);
      for (int e = 1; e <= 43; e++) begin
         @(negedge clk);
         if (e < 5) begin
            rx_data = 8'(8'h30 + e);
            exp_q.push_back(rx_data);
         end else if (e == 5) begin
            chk("full level", level, 4);
            chk("full rx_ready", rx_ready, 0);
            rx_data = 8'h35;
            exp_q.push_back(8'h35);
         end else if (e == 41) begin
            chk("pre-pop level", level, 4);
         end else if (e == 42) begin
            chk("pop rejects write level", level, 3);
            chk("pop rx_ready", rx_ready, 1);
         end else if (e == 43) begin
            chk("refill level", level, 4);
            rx_valid = 1'b0;
         end
      end
      wait_idle(400);
      chk("simul pending", exp_q.size(), 0);

      // reset during data bit 3 of 0x00 with two bytes queued
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'h00;
      @(negedge clk); rx_data = 8'hFF;
      @(negedge clk); rx_data = 8'h55;
      @(negedge clk); rx_valid = 1'b0;
      chk("queued level", level, 2);
      repeat (16) @(negedge clk);
      chk("mid-frame tx low", tx, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort tx", tx, 1);
      chk("abort level", level, 0);
      chk("abort busy", busy, 0);
      chk("abort rx_ready", rx_ready, 1);
      rst = 1'b1;
      lowseen = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) lowseen++;
      end
      chk("no frame after abort", lowseen, 0);
      chk("abort busy stays low", busy, 0);
      rx_data = 8'h5A; rx_valid = 1'b1; exp_q.push_back(8'h5A);
      @(negedge clk);
      rx_valid = 1'b0;
      wait_idle(200);
      chk("post-reset pending", exp_q.size(), 0);

      // 20-byte stream gated by rx_ready, wrapping the pointers
      for (int i = 0; i < 20; i++) exp_q.push_back(8'(8'h10 + i));
      idx = 0; n = 0;
      @(negedge clk);
      rx_data = 8'h10; rx_valid = 1'b1; rdy = rx_ready;
      while (idx < 20 && n < 3000) begin
         @(negedge clk);
         n++;
         if (rdy) idx++;
         rdy = rx_ready;
         if (idx < 20) rx_data = 8'(8'h10 + idx);
         else rx_valid = 1'b0;
      end
      rx_valid = 1'b0;
      chk("stream accepted", idx, 20);
      wait_idle(1500);
      chk("stream pending", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
